// File: rtl/arith_pkg.sv
// Shared types and the reference arithmetic for the 5-bit datapath front-end.
// The datapath's result function lives here so RTL and bench scoreboards use one definition.
package arith_pkg;

  localparam int DW = 5;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  typedef struct packed {
    logic [DW-1:0] exp1;
    logic [DW-1:0] exp2;
    logic [DW-1:0] exp3;
  } exp_t;

  // All intermediate terms wrap at DW bits, matching the datapath's register widths.
  function automatic exp_t arith_exp(input logic [DW-1:0] a,
                                     input logic [DW-1:0] b,
                                     input logic          sub);
    logic [DW-1:0] s;
    logic [DW-1:0] r;
    exp_t          e;
    s      = a + b;
    r      = sub ? (a - b) : s;
    e.exp1 = r + s;
    e.exp2 = s & ((a & b) + s);
    e.exp3 = e.exp2 - s;
    return e;
  endfunction

endpackage

// File: rtl/arith_ref_model.sv
// Combinational reference for the arithmetic datapath, fed from the registered operands.
module arith_ref_model
  import arith_pkg::*;
(
  input  logic [DW-1:0] a,
  input  logic [DW-1:0] b,
  input  logic          sub,
  output logic [DW-1:0] exp1,
  output logic [DW-1:0] exp2,
  output logic [DW-1:0] exp3
);

  exp_t e;

  assign e    = arith_exp(a, b, sub);
  assign exp1 = e.exp1;
  assign exp2 = e.exp2;
  assign exp3 = e.exp3;

endmodule

// File: rtl/arith_issue_ctrl.sv
// Issue/capture sequencer for the 5-bit arithmetic datapath with result self-check.
// state | meaning
// IDLE  | ready for a command; accept latches operands into dp_*
// WAIT  | dp_* held while the datapath pipeline settles; cnt counts down to capture
// RESP  | captured result presented downstream until res_ready
module arith_issue_ctrl
  import arith_pkg::*;
#(
  parameter int WAIT_CYC = 2
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          cmd_valid,
  output logic          cmd_ready,
  input  logic [DW-1:0] cmd_a,
  input  logic [DW-1:0] cmd_b,
  input  logic          cmd_sub,
  output logic [DW-1:0] dp_data1,
  output logic [DW-1:0] dp_data2,
  output logic          dp_sel,
  input  logic [DW-1:0] dp_out1,
  input  logic [DW-1:0] dp_out2,
  input  logic [DW-1:0] dp_out3,
  output logic          res_valid,
  input  logic          res_ready,
  output logic [DW-1:0] res_out1,
  output logic [DW-1:0] res_out2,
  output logic [DW-1:0] res_out3,
  output logic          res_err,
  output logic [7:0]    err_cnt,
  output logic          busy
);

  localparam logic [3:0] WAIT_LD = 4'(WAIT_CYC);

  state_t        state_q, state_d;
  logic [3:0]    cnt;
  logic          accept, capture, handshake;
  logic [DW-1:0] exp1, exp2, exp3;
  logic          mismatch;

  arith_ref_model u_ref (
    .a    (dp_data1),
    .b    (dp_data2),
    .sub  (dp_sel),
    .exp1 (exp1),
    .exp2 (exp2),
    .exp3 (exp3)
  );

  assign mismatch  = {dp_out1, dp_out2, dp_out3} != {exp1, exp2, exp3};
  assign cmd_ready = (state_q == IDLE);
  assign res_valid = (state_q == RESP);
  assign busy      = (state_q != IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d   = state_q;
    accept    = 1'b0;
    capture   = 1'b0;
    handshake = 1'b0;
    case (state_q)
      IDLE: if (cmd_valid) begin
        accept  = 1'b1;
        state_d = WAIT;
      end
      WAIT: if (cnt == 4'd0) begin
        capture = 1'b1;
        state_d = RESP;
      end
      RESP: if (res_ready) begin
        handshake = 1'b1;
        state_d   = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // dp_* only move on the accept edge so the datapath's second stage sees stable operands.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dp_data1 <= '0;
      dp_data2 <= '0;
      dp_sel   <= 1'b0;
      cnt      <= '0;
    end else if (accept) begin
      dp_data1 <= cmd_a;
      dp_data2 <= cmd_b;
      dp_sel   <= cmd_sub;
      cnt      <= WAIT_LD;
    end else if (state_q == WAIT && cnt != 4'd0) begin
      cnt <= cnt - 4'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      res_out1 <= '0;
      res_out2 <= '0;
      res_out3 <= '0;
      res_err  <= 1'b0;
      err_cnt  <= '0;
    end else begin
      if (capture) begin
        res_out1 <= dp_out1;
        res_out2 <= dp_out2;
        res_out3 <= dp_out3;
        res_err  <= mismatch;
      end
      if (handshake && res_err && err_cnt != 8'hFF)
        err_cnt <= err_cnt + 8'd1;
    end
  end

endmodule

// File: tb/tb_arith_issue_ctrl.sv
// Scoreboard bench for arith_issue_ctrl with a behavioural two-stage datapath model.
module tb_arith_issue_ctrl;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       cmd_valid = 1'b0;
  logic       cmd_ready;
  logic [4:0] cmd_a = '0, cmd_b = '0;
  logic       cmd_sub = 1'b0;
  logic [4:0] dp_data1, dp_data2;
  logic       dp_sel;
  logic [4:0] dp_out1, dp_out2, dp_out3;
  logic       res_valid;
  logic       res_ready = 1'b0;
  logic [4:0] res_out1, res_out2, res_out3;
  logic       res_err;
  logic [7:0] err_cnt;
  logic       busy;

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic [4:0] o1, o2, o3;
    logic       err;
  } exp_rec_t;

  exp_rec_t sb[$];

  always #5 clk = ~clk;

  arith_issue_ctrl dut (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_a(cmd_a), .cmd_b(cmd_b), .cmd_sub(cmd_sub),
    .dp_data1(dp_data1), .dp_data2(dp_data2), .dp_sel(dp_sel),
    .dp_out1(dp_out1), .dp_out2(dp_out2), .dp_out3(dp_out3),
    .res_valid(res_valid), .res_ready(res_ready),
    .res_out1(res_out1), .res_out2(res_out2), .res_out3(res_out3),
    .res_err(res_err), .err_cnt(err_cnt), .busy(busy)
  );

  function automatic logic [14:0] dp_fn(input logic [4:0] x, input logic [4:0] y, input logic sb_sub);
    logic [4:0] s, r, o1, o2, o3;
    s  = x + y;
    r  = sb_sub ? x - y : s;
    o1 = r + s;
    o2 = s & ((x & y) + s);
    o3 = o2 - s;
    return {o1, o2, o3};
  endfunction

  // Datapath stand-in: stage 1 latches operands, stage 2 latches results.
  logic [4:0] s1_a, s1_b, p1, p2, p3;
  logic       s1_sub;
  logic       bad = 1'b0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_a <= '0; s1_b <= '0; s1_sub <= 1'b0;
      p1 <= '0; p2 <= '0; p3 <= '0;
    end else begin
      s1_a <= dp_data1; s1_b <= dp_data2; s1_sub <= dp_sel;
      {p1, p2, p3} <= dp_fn(s1_a, s1_b, s1_sub);
    end
  end

  assign dp_out1 = bad ? 5'd7 : p1;
  assign dp_out2 = p2;
  assign dp_out3 = p3;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic send(input logic [4:0] a, input logic [4:0] b, input logic sub);
    @(negedge clk);
    check_val("cmd_ready_idle", cmd_ready, 1);
    cmd_valid = 1'b1; cmd_a = a; cmd_b = b; cmd_sub = sub;
    @(posedge clk);
    #1 cmd_valid = 1'b0;
  endtask

  task automatic wait_result(output int lat);
    logic got;
    lat = 0;
    got = 1'b0;
    while (lat < 20 && !got) begin
      @(posedge clk);
      lat++;
      @(negedge clk);
      got = res_valid;
    end
    check_val("latency", lat, 3);
  endtask

  task automatic compare_pop();
    exp_rec_t e;
    if (sb.size() == 0) begin
      check_val("sb_empty", 1, 0);
      return;
    end
    e = sb.pop_front();
    check_val("res_out1", res_out1, e.o1);
    check_val("res_out2", res_out2, e.o2);
    check_val("res_out3", res_out3, e.o3);
    check_val("res_err", res_err, e.err);
  endtask

  task automatic do_cmd(input logic [4:0] a, input logic [4:0] b, input logic sub,
                        input logic [4:0] e1, input logic [4:0] e2, input logic [4:0] e3,
                        input logic eerr);
    int lat;
    sb.push_back('{o1: e1, o2: e2, o3: e3, err: eerr});
    send(a, b, sub);
    wait_result(lat);
    compare_pop();
    res_ready = 1'b1;
    @(posedge clk);
    #1 res_ready = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    logic [14:0] r;
    logic [4:0]  a, b;
    logic        s;
    int          lat;

    repeat (3) @(negedge clk);
    check_val("rst_cmd_ready", cmd_ready, 1);
    check_val("rst_busy", busy, 0);
    check_val("rst_res_valid", res_valid, 0);
    check_val("rst_dp", {dp_data1, dp_data2, dp_sel}, 0);
    check_val("rst_res", {res_out1, res_out2, res_out3, res_err}, 0);
    check_val("rst_err_cnt", err_cnt, 0);
    rst_n = 1'b1;

    // Directed results from the worked examples
    do_cmd(5'd3, 5'd2, 1'b0, 5'd10, 5'd5, 5'd0, 1'b0);
    do_cmd(5'd3, 5'd2, 1'b1, 5'd6, 5'd5, 5'd0, 1'b0);
    do_cmd(5'd31, 5'd1, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0);
    @(negedge clk);
    check_val("err_cnt_clean", err_cnt, 0);
    check_val("idle_after_hs", busy, 0);

    for (int i = 0; i < 6; i++) begin
      a = 5'($urandom_range(0, 31));
      b = 5'($urandom_range(0, 31));
      s = 1'($urandom_range(0, 1));
      r = dp_fn(a, b, s);
      do_cmd(a, b, s, r[14:10], r[9:5], r[4:0], 1'b0);
    end

    bad = 1'b1;
    do_cmd(5'd3, 5'd2, 1'b0, 5'd7, 5'd5, 5'd0, 1'b1);
    bad = 1'b0;
    @(negedge clk);
    check_val("err_cnt_one", err_cnt, 1);

    // Backpressure with ignored command pulses
    r = dp_fn(5'd5, 5'd9, 1'b0);
    sb.push_back('{o1: r[14:10], o2: r[9:5], o3: r[4:0], err: 1'b0});
    send(5'd5, 5'd9, 1'b0);
    wait_result(lat);
    compare_pop();
    for (int i = 0; i < 10; i++) begin
      cmd_valid = (i % 2) == 0;
      cmd_a = 5'(i + 20); cmd_b = 5'(i); cmd_sub = 1'b1;
      @(negedge clk);
      check_val("bp_res_valid", res_valid, 1);
      check_val("bp_cmd_ready", cmd_ready, 0);
      check_val("bp_res_stable", {res_out1, res_out2, res_out3}, {r[14:10], r[9:5], r[4:0]});
      check_val("bp_dp_stable", {dp_data1, dp_data2, dp_sel}, {5'd5, 5'd9, 1'b0});
    end
    cmd_valid = 1'b0;
    res_ready = 1'b1;
    @(posedge clk);
    #1 res_ready = 1'b0;
    @(negedge clk);
    check_val("bp_back_idle", cmd_ready, 1);
    lat = 0;
    repeat (8) begin
      @(negedge clk);
      if (res_valid) lat++;
    end
    check_val("bp_no_extra", lat, 0);

    bad = 1'b1;
    for (int i = 0; i < 256; i++)
      do_cmd(5'd3, 5'd2, 1'b0, 5'd7, 5'd5, 5'd0, 1'b1);
    bad = 1'b0;
    @(negedge clk);
    check_val("err_cnt_sat", err_cnt, 255);

    // Reset while the command sits in WAIT
    send(5'd6, 5'd4, 1'b1);
    @(negedge clk);
    check_val("mid_busy_pre", busy, 1);
    rst_n = 1'b0;
    #1;
    check_val("mid_busy", busy, 0);
    check_val("mid_res_valid", res_valid, 0);
    check_val("mid_dp", {dp_data1, dp_data2, dp_sel}, 0);
    check_val("mid_cmd_ready", cmd_ready, 1);
    check_val("mid_err_cnt", err_cnt, 0);
    @(negedge clk);
    rst_n = 1'b1;
    lat = 0;
    repeat (10) begin
      @(negedge clk);
      if (res_valid || busy) lat++;
    end
    check_val("mid_no_result", lat, 0);

    do_cmd(5'd3, 5'd2, 1'b1, 5'd6, 5'd5, 5'd0, 1'b0);
    check_val("sb_drained", sb.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
